// File: rtl/memory_game_ctrl.sv
// Memory game controller: shows DISPLAY_CYCLE random values, records them in an
// external register file, then checks the player's entries. Optional input timeout: GAME_INPUT_TIMEOUT_EN.
module memory_game_ctrl #(
   parameter int DISPLAY_CYCLE = 10,
   parameter int TIMEOUT_TICKS = 20
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       game_tick_i,
   input  logic       start_key_i,
   input  logic       confirm_key_i,
   input  logic [9:0] rand_i,
   input  logic [9:0] sw_i,
   output logic       rf_we_o,
   output logic [3:0] rf_wn_o,
   output logic [9:0] rf_d_o,
   output logic [3:0] rf_rn_o,
   input  logic [9:0] rf_q_i,
   output logic [9:0] led_o,
   output logic [4:0] score_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHOW  = 3'd1,
      INPUT = 3'd2,
      CHECK = 3'd3,
      WIN   = 3'd4,
      LOSE  = 3'd5
   } state_e;

   localparam logic [4:0] DC    = 5'(DISPLAY_CYCLE);
   localparam logic [4:0] DC_M1 = 5'(DISPLAY_CYCLE - 1);

   if (DISPLAY_CYCLE < 1 || DISPLAY_CYCLE > 16 || TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255)
   begin : g_bad_param
      $error("memory_game_ctrl: DISPLAY_CYCLE or TIMEOUT_TICKS out of range");
   end

   state_e     state_q, state_d;
   logic [4:0] idx_q, idx_d;
   logic [4:0] score_q, score_d;
   logic [9:0] led_q, led_d;
   logic       rf_we_q, rf_we_d;
   logic [3:0] rf_wn_q, rf_wn_d;
   logic [9:0] rf_d_q, rf_d_d;
   logic       start_prev_q, confirm_prev_q;
   logic       start_edge, confirm_edge;

`ifdef GAME_INPUT_TIMEOUT_EN
   localparam logic [7:0] TMO = 8'(TIMEOUT_TICKS);
   logic [7:0] tmo_q, tmo_d;
`endif

   // Edges are taken from the live key against last cycle's sample.
   assign start_edge   = start_key_i & ~start_prev_q;
   assign confirm_edge = confirm_key_i & ~confirm_prev_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         score_q        <= '0;
         led_q          <= '0;
         rf_we_q        <= 1'b0;
         rf_wn_q        <= '0;
         rf_d_q         <= '0;
         start_prev_q   <= 1'b0;
         confirm_prev_q <= 1'b0;
`ifdef GAME_INPUT_TIMEOUT_EN
         tmo_q          <= '0;
`endif
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         score_q        <= score_d;
         led_q          <= led_d;
         rf_we_q        <= rf_we_d;
         rf_wn_q        <= rf_wn_d;
         rf_d_q         <= rf_d_d;
         start_prev_q   <= start_key_i;
         confirm_prev_q <= confirm_key_i;
`ifdef GAME_INPUT_TIMEOUT_EN
         tmo_q          <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      score_d = score_q;
      led_d   = led_q;
      rf_we_d = 1'b0;
      rf_wn_d = rf_wn_q;
      rf_d_d  = rf_d_q;
`ifdef GAME_INPUT_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         IDLE, WIN, LOSE: begin
            if (start_edge) begin
               state_d = SHOW;
               idx_d   = '0;
               score_d = '0;
               led_d   = '0;
            end
         end
         SHOW: begin
            if (game_tick_i) begin
               if (idx_q < DC) begin
                  led_d   = rand_i;
                  rf_we_d = 1'b1;
                  rf_wn_d = idx_q[3:0];
                  rf_d_d  = rand_i;
                  idx_d   = idx_q + 5'd1;
               end else begin
                  led_d   = '0;
                  idx_d   = '0;
                  state_d = INPUT;
`ifdef GAME_INPUT_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end
            end
         end
         INPUT: begin
            // A confirm wins over a simultaneous tick.
            if (confirm_edge) begin
               state_d = CHECK;
            end
`ifdef GAME_INPUT_TIMEOUT_EN
            else if (game_tick_i) begin
               tmo_d = tmo_q + 8'd1;
               if (tmo_d == TMO) state_d = LOSE;
            end
`endif
         end
         CHECK: begin
            if (sw_i == rf_q_i) begin
               score_d = (score_q < DC) ? score_q + 5'd1 : score_q;
               if (idx_q == DC_M1) begin
                  state_d = WIN;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = INPUT;
`ifdef GAME_INPUT_TIMEOUT_EN
                  tmo_d   = '0;
`endif
               end
            end else begin
               state_d = LOSE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case (state_q)
         INPUT:   led_o = sw_i;
         WIN:     led_o = 10'h3FF;
         LOSE:    led_o = 10'h155;
         default: led_o = led_q;
      endcase
   end

   assign rf_we_o = rf_we_q;
   assign rf_wn_o = rf_wn_q;
   assign rf_d_o  = rf_d_q;
   // During INPUT and CHECK the read port points at the value being guessed.
   assign rf_rn_o = idx_q[3:0];
   assign score_o = score_q;
   assign state_o = state_q;

endmodule
